csa_final_adder_seq: RTL and testbench



---
 rtl/csa_final_adder_seq.sv | 137 +++++++++++++
 tb/tb_csa_final_adder_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_final_adder_seq.sv
// Sequential carry-propagate adder that resolves a CSA sum/carry pair 8 bits per clock.
// Optional macro CSA_FINAL_ADDER_BACK_TO_BACK_EN lets a new pair be accepted while a result is delivered.
module csa_final_adder_seq #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);
    localparam int N = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             armed_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] carry_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             c_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [SLICE-1:0] sum_slices   [N];
    logic [SLICE-1:0] carry_slices [N];
    logic [SLICE:0]   slice_res;
    logic             accept;
    logic             last_slice;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign sum_slices[gi]   = sum_reg[gi*SLICE +: SLICE];
            assign carry_slices[gi] = carry_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    assign slice_res  = {1'b0, sum_slices[idx_reg]} + {1'b0, carry_slices[idx_reg]}
                      + {{SLICE{1'b0}}, c_reg};
    assign last_slice = (idx_reg == LAST_IDX);
    assign accept     = in_valid && in_ready;
    assign out_result = result_reg;
    assign out_cout   = cout_reg;

    // Partial result with the current slice merged in; only published on the last slice.
    always_comb begin
        acc_next = acc_reg;
        acc_next[int'(idx_reg) * SLICE +: SLICE] = slice_res[SLICE-1:0];
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = armed_reg;
                if (in_valid && armed_reg) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
`ifdef CSA_FINAL_ADDER_BACK_TO_BACK_EN
                in_ready = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? ADD : IDLE;
                end
`else
                if (out_ready) begin
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // armed_reg keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg    <= '0;
            carry_reg  <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            c_reg      <= 1'b0;
            idx_reg    <= '0;
        end else if (accept) begin
            sum_reg   <= in_sum;
            carry_reg <= in_carry;
            acc_reg   <= '0;
            c_reg     <= 1'b0;
            idx_reg   <= '0;
        end else if (state_reg == ADD) begin
            acc_reg <= acc_next;
            c_reg   <= slice_res[SLICE];
            if (last_slice) begin
                result_reg <= acc_next;
                cout_reg   <= slice_res[SLICE];
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_csa_final_adder_seq.sv
// Self-checking bench for csa_final_adder_seq (WIDTH=64) against a plain 65-bit addition model.
module tb_csa_final_adder_seq;
    localparam int WIDTH = 64;
`ifdef CSA_FINAL_ADDER_BACK_TO_BACK_EN
    localparam int SPACING = 9;
    localparam int ACC_OFF = 0;
`else
    localparam int SPACING = 10;
    localparam int ACC_OFF = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    csa_final_adder_seq #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: the result is just the unsigned 65-bit sum of the two vectors.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        return {1'b0, s} + {1'b0, c};
    endfunction

    // Offers one pair, waits for the result; lat = edges from accept to out_valid.
    task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                          output logic [WIDTH-1:0] r, output logic co,
                          output int lat, output bit to);
        int n;
        to = 1'b0; r = '0; co = 1'b0; lat = 0; n = 0;
        @(negedge clk);
        in_sum = s; in_carry = c; in_valid = 1'b1; out_ready = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sum   = {$urandom(), $urandom()};
        in_carry = {$urandom(), $urandom()};
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        r  = out_result;
        co = out_cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_carry = '0;
        #12;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++;
        if (out_result !== '0) $display("FAIL reset_out_result got=%h exp=0", out_result); else n_pass++;
        n_checks++;
        if (out_cout !== 1'b0) $display("FAIL reset_out_cout got=%b exp=0", out_cout); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL release_in_ready_before_edge got=%b exp=0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready_after_edge got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic check_op(input string name, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] r;
        logic             co;
        logic [WIDTH:0]   exp;
        int               lat;
        bit               to;
        exp = model(s, c);
        run_op(s, c, r, co, lat, to);
        $display("%s: sum=%h carry=%h -> result=%h cout=%b lat=%0d", name, s, c, r, co, lat);
        n_checks++;
        if (to) $display("FAIL %s_timeout got=timeout exp=result", name); else n_pass++;
        n_checks++;
        if (r !== exp[WIDTH-1:0]) $display("FAIL %s_result got=%h exp=%h", name, r, exp[WIDTH-1:0]); else n_pass++;
        n_checks++;
        if (co !== exp[WIDTH]) $display("FAIL %s_cout got=%b exp=%b", name, co, exp[WIDTH]); else n_pass++;
        n_checks++;
        if (lat != 8) $display("FAIL %s_latency got=%0d exp=8", name, lat); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL %s_valid_one_cycle got=%b exp=0", name, out_valid); else n_pass++;
    endtask

    task automatic test_directed();
        check_op("dir_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
        check_op("dir_small", 64'h0000_0000_1234_5678, 64'h0000_0000_0000_0008);
        check_op("dir_slice", 64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001);
        check_op("dir_alt", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        for (int i = 0; i < 16; i++) begin
            s = {$urandom(), $urandom()};
            c = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: s = '1;
                1: c = ~s;
                2: c = ~s + 64'd1;
                default: ;
            endcase
            check_op("rand", s, c);
        end
    endtask

    task automatic test_backpressure();
        int  n;
        int  stray;
        logic [WIDTH-1:0] exp;
        exp = 64'hFFFF_FFFF_FFFF_FFFF;
        n = 0;
        @(negedge clk);
        in_sum = 64'hAAAA_AAAA_AAAA_AAAA; in_carry = 64'h5555_5555_5555_5555;
        in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_sum = 64'h0000_0000_0000_0123; in_carry = 64'h0000_0000_0000_0456;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", k, out_valid); else n_pass++;
            n_checks++;
            if (out_result !== exp) $display("FAIL bp_result[%0d] got=%h exp=%h", k, out_result, exp); else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); else n_pass++;
            @(negedge clk);
        end
        $display("backpressure: held result=%h cout=%b for 5 cycles", out_result, out_cout);
        n_checks++;
        if (out_cout !== 1'b0) $display("FAIL bp_cout got=%b exp=0", out_cout); else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else n_pass++;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL bp_no_stray_result got=%0d exp=0", stray); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int n;
        int stray;
        n = 0;
        @(negedge clk);
        in_sum = 64'h0123_4567_89AB_CDEF; in_carry = {$urandom(), $urandom()};
        in_valid = 1'b1; out_ready = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset_mid_op: rst_n asserted in 4th ADD cycle");
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++;
        if (out_result !== '0) $display("FAIL rst_mid_result got=%h exp=0", out_result); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_ready_after got=%b exp=1", in_ready); else n_pass++;
        stray = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL rst_mid_stale_result got=%0d exp=0", stray); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ps [2];
        logic [WIDTH-1:0] pc [2];
        logic [WIDTH-1:0] rres [2];
        logic             rco [2];
        logic [WIDTH:0]   exp;
        int  rise [2];
        int  acc_cyc [2];
        int  cyc;
        int  idx;
        int  nrise;
        bit  pending;
        bit  prev;
        for (int i = 0; i < 2; i++) begin
            ps[i] = {$urandom(), $urandom()};
            pc[i] = {$urandom(), $urandom()};
            rise[i] = -100;
            acc_cyc[i] = -100;
            rres[i] = '0;
            rco[i] = 1'b0;
        end
        idx = 0; nrise = 0; pending = 1'b0; cyc = 0;
        @(negedge clk);
        in_sum = ps[0]; in_carry = pc[0]; in_valid = 1'b1; out_ready = 1'b1;
        prev = out_valid;
        for (int k = 0; k < 60 && nrise < 2; k++) begin
            if (in_valid && in_ready && idx < 2) begin
                pending = 1'b1;
                acc_cyc[idx] = cyc;
            end
            @(negedge clk);
            cyc++;
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx < 2) begin
                    in_sum = ps[idx]; in_carry = pc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && !prev) begin
                rise[nrise] = cyc;
                rres[nrise] = out_result;
                rco[nrise]  = out_cout;
                nrise++;
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        $display("back_to_back: accepts at %0d,%0d results at %0d,%0d", acc_cyc[0], acc_cyc[1], rise[0], rise[1]);
        n_checks++;
        if (nrise != 2) $display("FAIL b2b_result_count got=%0d exp=2", nrise); else n_pass++;
        n_checks++;
        if (rise[0] - acc_cyc[0] != 9) $display("FAIL b2b_first_latency got=%0d exp=9", rise[0] - acc_cyc[0]); else n_pass++;
        n_checks++;
        if (rise[1] - rise[0] != SPACING) $display("FAIL b2b_spacing got=%0d exp=%0d", rise[1] - rise[0], SPACING); else n_pass++;
        n_checks++;
        if (acc_cyc[1] - rise[0] != ACC_OFF) $display("FAIL b2b_second_accept got=%0d exp=%0d", acc_cyc[1] - rise[0], ACC_OFF); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            exp = model(ps[i], pc[i]);
            n_checks++;
            if (rres[i] !== exp[WIDTH-1:0]) $display("FAIL b2b_result[%0d] got=%h exp=%h", i, rres[i], exp[WIDTH-1:0]); else n_pass++;
            n_checks++;
            if (rco[i] !== exp[WIDTH]) $display("FAIL b2b_cout[%0d] got=%b exp=%b", i, rco[i], exp[WIDTH]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
